ref_cmp_engine: RTL and testbench
=================================

Name: ref_cmp_engine

Overview:
- Sits directly downstream of vec_cat and consumes its concatenated, ID-tagged fingerprint vectors.
- After reset, or after a completed set, the first REF_VEC_NO accepted vectors are stored as reference vectors.
- Every later vector is a compare vector. It is paired with each stored reference in turn.
- For each pair the block emits popcount(cmp AND ref), popcount(cmp) and popcount(ref), with both IDs. These feed the downstream similarity (Tanimoto) stage.

Parameters:
VECTOR_WIDTH, 128, bits per fingerprint vector
VEC_ID_WIDTH, 8, width of vector ID
REF_VEC_NO, 8, number of reference vectors held (>=2)
CNT_WIDTH, 8, popcount width; must satisfy 2^CNT_WIDTH > VECTOR_WIDTH

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  synchronous active-low reset
i_Vector  in  VECTOR_WIDTH  full vector from vec_cat
i_VecID  in  VEC_ID_WIDTH  ID of i_Vector
i_Valid  in  1  i_Vector/i_VecID/i_Last valid
i_Last  in  1  marks final vector of the set
o_Ready  out  1  block accepts input this cycle (combinational from state/index only)
o_CmpID  out  VEC_ID_WIDTH  compare vector ID
o_RefID  out  VEC_ID_WIDTH  reference vector ID
o_AndCnt  out  CNT_WIDTH  popcount(cmp & ref)
o_CmpCnt  out  CNT_WIDTH  popcount(cmp)
o_RefCnt  out  CNT_WIDTH  popcount(ref)
o_Valid  out  1  output tuple valid
o_Last  out  1  final tuple of the set

Behaviour:
- Reset
  - Synchronous, applies whenever rstn=0, including mid-operation.
  - state=LOAD, ref write index=0, compare index=0, pipeline valid bits=0.
  - All outputs 0.
  - Stored refs need not be cleared.
- Transfer rule: a transfer occurs when i_Valid && o_Ready. When no transfer occurs, inputs are ignored.
- LOAD state
  - o_Ready=1.
  - Each transfer writes the vector, its ID and its popcount into slot ref_wr, then ref_wr increments.
  - On the transfer into slot REF_VEC_NO-1: go to WAIT_CMP and set ref_wr=0.
  - i_Last on a LOAD transfer aborts the set: ref_wr=0, state stays LOAD, no output is produced.
- WAIT_CMP state
  - o_Ready=1.
  - On a transfer: latch the vector, its ID, popcount(vector) and i_Last into the cmp registers; set idx=0; go to COMPARE.
- COMPARE state
  - Each cycle issues the pair (cmp, ref[idx]), then idx increments.
  - o_Ready=0 while idx<REF_VEC_NO-1.
  - o_Ready=1 on the idx=REF_VEC_NO-1 cycle, which allows gapless back-to-back compares.
  - At idx=REF_VEC_NO-1, in priority order:
    - if the latched last flag is set: go to LOAD, ref_wr=0. o_Ready is 0 on this cycle, so no new vector is taken.
    - else if a transfer occurs: latch the new cmp, idx=0, stay in COMPARE.
    - else: go to WAIT_CMP.
- Throughput
  - REF_VEC_NO cycles per compare vector when input is continuous.
  - REF_VEC_NO+1 cycles when the upstream is one cycle late.
- Output pipeline
  - Stage 1 registers cmp&ref[idx], the IDs, the counts and a last tag.
  - Stage 2 registers the popcount of the AND onto the outputs.
  - Latency: a pair issued in cycle N appears on the outputs in cycle N+2 with o_Valid=1.
- o_Last=1 only with the tuple for ref slot REF_VEC_NO-1 of a compare vector whose latched last flag is set. It is otherwise 0.
- When no pair is issued, o_Valid=0 and o_Last=0 two cycles later. Data outputs then hold their previous values.
- No output backpressure: the consumer must accept every o_Valid cycle.
- Popcounts are unsigned. The maximum value VECTOR_WIDTH must fit in CNT_WIDTH; there is no saturation or wrap.
- Set boundary: the compare issue for the last-tagged vector completes before LOAD begins. Tuples still in flight in the pipeline drain normally after the state change.

Test Plan:
- Basic set
  - Stimulus after reset: 8 refs with ref k = k+1 ones in LSBs, IDs 0..7. Then one compare vector, all ones, ID 8, i_Last=1.
  - Required: 8 tuples on consecutive cycles; RefID 0..7; AndCnt=RefCnt=1..8; CmpCnt=128; o_Last only on RefID 7; state returns to LOAD.
- Back-to-back compares
  - Stimulus: i_Valid held high for 3 compare vectors.
  - Required: 24 consecutive o_Valid cycles, no gaps; o_Ready pulses once every 8 cycles.
- Disjoint and empty vectors
  - Stimulus: cmp = 0xAAAA…, refs = 0x5555…; also a cmp of all zeros.
  - Required: AndCnt=0, CmpCnt=64 and RefCnt=64 for the first; CmpCnt=0 and AndCnt=0 for the zero vector.
- Upstream gaps
  - Stimulus: i_Valid toggled 1/0 during LOAD and between compare vectors.
  - Required: no spurious writes; tuples appear exactly 2 cycles after each issue cycle.
- Mid-operation reset
  - Stimulus: rstn=0 during COMPARE at idx=3.
  - Required: o_Valid=0 from the cycle after the reset edge; next vectors load as refs starting at slot 0.
- Abort during LOAD
  - Stimulus: i_Last on the 4th ref.
  - Required: no outputs produced; the following 8 vectors load as slots 0..7.

Source files
------------

// File: rtl/ref_cmp_engine.sv
// rtl/ref_cmp_engine.sv - reference/compare popcount engine for fingerprint similarity
//
// Stores the first REF_VEC_NO vectors of a set as references.
// Pairs every later (compare) vector with each stored reference in turn.
// For each pair it emits popcount(cmp & ref), popcount(cmp), popcount(ref) and both IDs.
//
// Ports:
//   clk       rising-edge clock
//   rstn      synchronous active-low reset
//   i_Vector  input fingerprint vector
//   i_VecID   ID of i_Vector
//   i_Valid   input qualifier
//   i_Last    final vector of the set
//   o_Ready   input accepted this cycle when i_Valid is high
//   o_CmpID   compare vector ID
//   o_RefID   reference vector ID
//   o_AndCnt  popcount(cmp & ref)
//   o_CmpCnt  popcount(cmp)
//   o_RefCnt  popcount(ref)
//   o_Valid   output tuple valid
//   o_Last    final tuple of the set
module ref_cmp_engine #(
  parameter int VECTOR_WIDTH = 128,
  parameter int VEC_ID_WIDTH = 8,
  parameter int REF_VEC_NO   = 8,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [VECTOR_WIDTH-1:0] i_Vector,
  input  logic [VEC_ID_WIDTH-1:0] i_VecID,
  input  logic                    i_Valid,
  input  logic                    i_Last,
  output logic                    o_Ready,
  output logic [VEC_ID_WIDTH-1:0] o_CmpID,
  output logic [VEC_ID_WIDTH-1:0] o_RefID,
  output logic [CNT_WIDTH-1:0]    o_AndCnt,
  output logic [CNT_WIDTH-1:0]    o_CmpCnt,
  output logic [CNT_WIDTH-1:0]    o_RefCnt,
  output logic                    o_Valid,
  output logic                    o_Last
);

  localparam int IDX_W = $clog2(REF_VEC_NO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REF_VEC_NO - 1);

  localparam logic [1:0] ST_LOAD     = 2'd0;
  localparam logic [1:0] ST_WAIT_CMP = 2'd1;
  localparam logic [1:0] ST_COMPARE  = 2'd2;

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [VECTOR_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < VECTOR_WIDTH; i++) begin
      c = c + CNT_WIDTH'(v[i]);
    end
    return c;
  endfunction

  logic [1:0]       state;
  logic [IDX_W-1:0] ref_wr;
  logic [IDX_W-1:0] idx;

  // Reference store; contents are only meaningful once a full set is loaded.
  logic [VECTOR_WIDTH-1:0] ref_vec [REF_VEC_NO];
  logic [VEC_ID_WIDTH-1:0] ref_id  [REF_VEC_NO];
  logic [CNT_WIDTH-1:0]    ref_cnt [REF_VEC_NO];

  logic [VECTOR_WIDTH-1:0] cmp_vec;
  logic [VEC_ID_WIDTH-1:0] cmp_id;
  logic [CNT_WIDTH-1:0]    cmp_cnt;
  logic                    cmp_last;

  logic [CNT_WIDTH-1:0] in_cnt;
  logic                 xfer;
  logic                 at_last;
  logic                 issue;
  logic                 cmp_load;

  assign in_cnt   = popcount(i_Vector);
  assign at_last  = (idx == LAST_IDX);
  assign issue    = (state == ST_COMPARE);
  assign xfer     = i_Valid && o_Ready;
  // A compare vector is latched from WAIT_CMP or from the final COMPARE cycle.
  assign cmp_load = xfer && (state != ST_LOAD);

  // Ready opens on the last compare cycle so the next vector can follow
  // without a bubble, except when this compare closes the set.
  always_comb begin
    o_Ready = 1'b0;
    case (state)
      ST_LOAD:     o_Ready = 1'b1;
      ST_WAIT_CMP: o_Ready = 1'b1;
      ST_COMPARE:  o_Ready = at_last && !cmp_last;
      default:     o_Ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= ST_LOAD;
      ref_wr <= '0;
      idx    <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (xfer) begin
            if (i_Last) begin
              // Set ended before the references were complete: discard it.
              ref_wr <= '0;
            end else if (ref_wr == LAST_IDX) begin
              ref_wr <= '0;
              state  <= ST_WAIT_CMP;
            end else begin
              ref_wr <= ref_wr + IDX_W'(1);
            end
          end
        end
        ST_WAIT_CMP: begin
          if (xfer) begin
            idx   <= '0;
            state <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          if (at_last) begin
            if (cmp_last) begin
              ref_wr <= '0;
              state  <= ST_LOAD;
            end else if (xfer) begin
              idx <= '0;
            end else begin
              state <= ST_WAIT_CMP;
            end
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
          state  <= ST_LOAD;
          ref_wr <= '0;
          idx    <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (xfer && (state == ST_LOAD)) begin
      ref_vec[ref_wr] <= i_Vector;
      ref_id[ref_wr]  <= i_VecID;
      ref_cnt[ref_wr] <= in_cnt;
    end
    if (cmp_load) begin
      cmp_vec  <= i_Vector;
      cmp_id   <= i_VecID;
      cmp_cnt  <= in_cnt;
      cmp_last <= i_Last;
    end
  end

  // Stage 1: AND of the issued pair plus its side-band fields.
  logic                    s1_valid;
  logic                    s1_last;
  logic [VECTOR_WIDTH-1:0] s1_and;
  logic [VEC_ID_WIDTH-1:0] s1_cmp_id;
  logic [VEC_ID_WIDTH-1:0] s1_ref_id;
  logic [CNT_WIDTH-1:0]    s1_cmp_cnt;
  logic [CNT_WIDTH-1:0]    s1_ref_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_and     <= '0;
      s1_cmp_id  <= '0;
      s1_ref_id  <= '0;
      s1_cmp_cnt <= '0;
      s1_ref_cnt <= '0;
    end else begin
      s1_valid <= issue;
      if (issue) begin
        s1_and     <= cmp_vec & ref_vec[idx];
        s1_cmp_id  <= cmp_id;
        s1_ref_id  <= ref_id[idx];
        s1_cmp_cnt <= cmp_cnt;
        s1_ref_cnt <= ref_cnt[idx];
        s1_last    <= cmp_last && at_last;
      end
    end
  end

  // Stage 2: popcount of the AND; data holds when no tuple arrives.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_Valid  <= 1'b0;
      o_Last   <= 1'b0;
      o_CmpID  <= '0;
      o_RefID  <= '0;
      o_AndCnt <= '0;
      o_CmpCnt <= '0;
      o_RefCnt <= '0;
    end else begin
      o_Valid <= s1_valid;
      o_Last  <= s1_valid && s1_last;
      if (s1_valid) begin
        o_CmpID  <= s1_cmp_id;
        o_RefID  <= s1_ref_id;
        o_AndCnt <= popcount(s1_and);
        o_CmpCnt <= s1_cmp_cnt;
        o_RefCnt <= s1_ref_cnt;
      end
    end
  end

endmodule

// File: tb/tb_ref_cmp_engine.sv
// tb/tb_ref_cmp_engine.sv - self-checking bench for ref_cmp_engine
module tb_ref_cmp_engine;

  localparam int VW   = 128;
  localparam int IW   = 8;
  localparam int N    = 8;
  localparam int CW   = 8;
  localparam int MAXC = 8192;
  localparam int INF  = 1 << 30;

  logic          clk = 1'b0;
  logic          rstn;
  logic [VW-1:0] i_Vector;
  logic [IW-1:0] i_VecID;
  logic          i_Valid;
  logic          i_Last;
  logic          o_Ready;
  logic [IW-1:0] o_CmpID;
  logic [IW-1:0] o_RefID;
  logic [CW-1:0] o_AndCnt;
  logic [CW-1:0] o_CmpCnt;
  logic [CW-1:0] o_RefCnt;
  logic          o_Valid;
  logic          o_Last;

  always #5 clk = ~clk;

  ref_cmp_engine #(
    .VECTOR_WIDTH(VW),
    .VEC_ID_WIDTH(IW),
    .REF_VEC_NO(N),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .i_Vector(i_Vector),
    .i_VecID(i_VecID),
    .i_Valid(i_Valid),
    .i_Last(i_Last),
    .o_Ready(o_Ready),
    .o_CmpID(o_CmpID),
    .o_RefID(o_RefID),
    .o_AndCnt(o_AndCnt),
    .o_CmpCnt(o_CmpCnt),
    .o_RefCnt(o_RefCnt),
    .o_Valid(o_Valid),
    .o_Last(o_Last)
  );

  int checks = 0;
  int errors = 0;
  int t = 0;

  // Reference model: set-level bookkeeping plus a timeline of expected tuples.
  bit            m_load;
  int            m_nrefs;
  logic [VW-1:0] m_rv [N];
  logic [IW-1:0] m_rid [N];
  int            m_block_end;
  int            m_load_at;
  bit            m_xfer;

  bit            ev  [MAXC];
  bit            el  [MAXC];
  logic [IW-1:0] ec  [MAXC];
  logic [IW-1:0] er  [MAXC];
  logic [CW-1:0] ea  [MAXC];
  logic [CW-1:0] ecc [MAXC];
  logic [CW-1:0] erc [MAXC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step(input logic v, input logic [VW-1:0] vec, input logic [IW-1:0] id, input logic last);
    bit rdy;
    i_Valid  = v;
    i_Vector = vec;
    i_VecID  = id;
    i_Last   = last;
    @(negedge clk);
    if (t >= m_load_at) begin
      m_load    = 1'b1;
      m_nrefs   = 0;
      m_load_at = INF;
    end
    rdy = m_load || (t > m_block_end);
    chk("ready", 32'(o_Ready), 32'(rdy));
    chk("valid", 32'(o_Valid), 32'(ev[t]));
    if (ev[t]) begin
      chk("cmp_id",  32'(o_CmpID),  32'(ec[t]));
      chk("ref_id",  32'(o_RefID),  32'(er[t]));
      chk("and_cnt", 32'(o_AndCnt), 32'(ea[t]));
      chk("cmp_cnt", 32'(o_CmpCnt), 32'(ecc[t]));
      chk("ref_cnt", 32'(o_RefCnt), 32'(erc[t]));
      chk("last",    32'(o_Last),   32'(el[t]));
    end else begin
      chk("last_idle", 32'(o_Last), 32'd0);
    end
    m_xfer = v && rdy;
    if (m_xfer) begin
      if (m_load) begin
        m_rv[m_nrefs]  = vec;
        m_rid[m_nrefs] = id;
        if (last) begin
          m_nrefs = 0;
        end else begin
          m_nrefs++;
          if (m_nrefs == N) begin
            m_load      = 1'b0;
            m_block_end = t;
          end
        end
      end else begin
        // Pair k is issued at t+1+k and shows up two cycles later.
        for (int k = 0; k < N; k++) begin
          int o;
          o = t + 3 + k;
          if (o < MAXC) begin
            ev[o]  = 1'b1;
            ec[o]  = id;
            er[o]  = m_rid[k];
            ea[o]  = CW'($countones(vec & m_rv[k]));
            ecc[o] = CW'($countones(vec));
            erc[o] = CW'($countones(m_rv[k]));
            el[o]  = last && (k == N - 1);
          end
        end
        if (last) begin
          m_block_end = t + N;
          m_load_at   = t + N + 1;
        end else begin
          m_block_end = t + N - 1;
        end
      end
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, rand_vec(), IW'($urandom), 1'($urandom));
    end
  endtask

  task automatic send(input logic [VW-1:0] vec, input logic [IW-1:0] id, input logic last);
    int tries;
    tries = 0;
    do begin
      step(1'b1, vec, id, last);
      tries++;
    end while (!m_xfer && tries < 40);
    chk("send_accepted", 32'(m_xfer), 32'd1);
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    i_Valid = 1'b0;
    @(negedge clk);
    chk("valid_pre_reset", 32'(o_Valid), 32'(ev[t]));
    @(posedge clk);
    #1;
    t++;
    rstn = 1'b1;
    for (int k = t; k < MAXC; k++) ev[k] = 1'b0;
    m_load      = 1'b1;
    m_nrefs     = 0;
    m_block_end = -1;
    m_load_at   = INF;
    chk("rst_valid",   32'(o_Valid),  32'd0);
    chk("rst_last",    32'(o_Last),   32'd0);
    chk("rst_ready",   32'(o_Ready),  32'd1);
    chk("rst_and_cnt", 32'(o_AndCnt), 32'd0);
    chk("rst_cmp_cnt", 32'(o_CmpCnt), 32'd0);
    chk("rst_ref_cnt", 32'(o_RefCnt), 32'd0);
    chk("rst_cmp_id",  32'(o_CmpID),  32'd0);
    chk("rst_ref_id",  32'(o_RefID),  32'd0);
  endtask

  task automatic load_refs(input int base_id, input int max_gap);
    for (int k = 0; k < N; k++) begin
      send(rand_vec() & rand_vec() | ({VW{1'b1}} >> $urandom_range(VW - 1, 0)) & rand_vec(),
           IW'(base_id + k), 1'b0);
      idle($urandom_range(max_gap, 0));
    end
  endtask

  logic [VW-1:0] one_v;

  initial begin
    rstn     = 1'b0;
    i_Valid  = 1'b0;
    i_Vector = '0;
    i_VecID  = '0;
    i_Last   = 1'b0;
    one_v    = 1;
    @(posedge clk);
    #1;
    do_reset();

    // Basic set: ref k has k+1 low ones, then an all-ones compare closes the set.
    for (int k = 0; k < N; k++) send((one_v << (k + 1)) - one_v, IW'(k), 1'b0);
    send({VW{1'b1}}, 8'd8, 1'b1);
    idle(12);

    // Back-to-back compares with i_Valid held high.
    load_refs(16, 0);
    send(rand_vec(), 8'd40, 1'b0);
    send(rand_vec(), 8'd41, 1'b0);
    send(rand_vec(), 8'd42, 1'b1);
    idle(12);

    // Disjoint and empty vectors.
    for (int k = 0; k < N; k++) send({(VW/4){4'h5}}, IW'(50 + k), 1'b0);
    send({(VW/4){4'hA}}, 8'd60, 1'b0);
    send('0, 8'd61, 1'b1);
    idle(12);

    // Upstream gaps during load and between compares.
    load_refs(70, 2);
    send(rand_vec(), 8'd80, 1'b0);
    idle(9);
    send(rand_vec(), 8'd81, 1'b0);
    idle(1);
    send(rand_vec(), 8'd82, 1'b1);
    idle(12);

    // Reset while COMPARE is at idx=3.
    load_refs(90, 0);
    send(rand_vec(), 8'd99, 1'b0);
    idle(3);
    do_reset();
    idle(3);
    load_refs(100, 1);
    send(rand_vec(), 8'd110, 1'b1);
    idle(12);

    // Abort on the fourth reference, then a full set.
    for (int k = 0; k < 3; k++) send(rand_vec(), IW'(120 + k), 1'b0);
    send(rand_vec(), 8'd123, 1'b1);
    idle(4);
    load_refs(130, 0);
    send(rand_vec(), 8'd140, 1'b1);
    idle(12);

    // Randomised sets.
    for (int s = 0; s < 4; s++) begin
      int ncmp;
      load_refs(150 + 10 * s, 2);
      ncmp = $urandom_range(4, 1);
      for (int c = 0; c < ncmp; c++) begin
        send(rand_vec(), IW'(200 + c), (c == ncmp - 1) ? 1'b1 : 1'b0);
        idle($urandom_range(9, 0));
      end
      idle(3);
    end
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
